// File: rtl/div_iter_pkg.sv
// rtl/div_iter_pkg.sv - shared width constant for execute-stage divider users
package div_iter_pkg;

  // Execute-stage consumers (HI/LO write path, hazard unit) size against this.
  localparam int DIV_WIDTH = 32;

endpackage

// File: rtl/div_iter_mux2.sv
// rtl/div_iter_mux2.sv - two-input select used for magnitude and sign fixups
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational radix-2 restoring division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem_in, dvd_bit};
  assign diff    = shifted - {2'b00, divisor};

  // A non-negative trial difference keeps the subtraction; otherwise restore.
  always_comb begin
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_iter.sv
// rtl/div_iter.sv - multicycle restoring divider for DIV/DIVU beside the ALU
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;

  logic load, div0, step_en, finish;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_inv, b_inv, a_mag, b_mag;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_raw, q_inv, q_fix;
  logic [WIDTH-1:0] r_raw, r_inv, r_fix;

  // Operand magnitudes; DIVU never negates.
  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];
  assign a_inv = -a;
  assign b_inv = -b;

  mux2 #(.WIDTH(WIDTH)) u_a_mag (.d0(a), .d1(a_inv), .sel(a_neg), .y(a_mag));
  mux2 #(.WIDTH(WIDTH)) u_b_mag (.d0(b), .d1(b_inv), .sel(b_neg), .y(b_mag));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Final step result is fixed up combinationally so ready lands in DONE.
  assign q_raw = {dvd_q[WIDTH-2:0], step_q};
  assign r_raw = step_rem[WIDTH-1:0];
  assign q_inv = -q_raw;
  assign r_inv = -r_raw;

  mux2 #(.WIDTH(WIDTH)) u_q_fix (.d0(q_raw), .d1(q_inv), .sel(neg_q_q), .y(q_fix));
  mux2 #(.WIDTH(WIDTH)) u_r_fix (.d0(r_raw), .d1(r_inv), .sel(neg_r_q), .y(r_fix));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    div0      = 1'b0;
    step_en   = 1'b0;
    finish    = 1'b0;
    stall     = 1'b0;
    case (state)
      S_IDLE: begin
        stall = start & ~annul;
        if (start & ~annul) begin
          if (b == '0) begin
            div0      = 1'b1;
            state_nxt = S_DONE;
          end else begin
            load      = 1'b1;
            state_nxt = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall   = 1'b1;
        step_en = 1'b1;
        if (cnt_q == CW'(1)) begin
          finish    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // A flush wins over any transition and suppresses every result update.
    if (annul) begin
      state_nxt = S_IDLE;
      load      = 1'b0;
      div0      = 1'b0;
      step_en   = 1'b0;
      finish    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ready <= finish | div0;
      busy  <= (state_nxt != S_IDLE);
      if (load) begin
        rem_q   <= '0;
        dvd_q   <= a_mag;
        dsr_q   <= b_mag;
        cnt_q   <= CW'(WIDTH);
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
      end
      if (step_en) begin
        rem_q <= step_rem;
        dvd_q <= q_raw;
        cnt_q <= cnt_q - CW'(1);
      end
      if (finish) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
      if (div0) begin
        quotient  <= '1;
        remainder <= a;
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb/tb_div_iter.sv - directed vector bench for div_iter
module tb_div_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        ready;
  logic        busy;
  logic        stall;

  int checks;
  int errors;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  div_iter #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .quotient   (quotient),
    .remainder  (remainder),
    .ready      (ready),
    .busy       (busy),
    .stall      (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] va, input logic [31:0] vb, input logic vs);
    @(negedge clk);
    a = va;
    b = vb;
    signed_div = vs;
    start = 1'b1;
    #1 check("stall_req", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles from 'first' until ready; lat stays 0 on timeout.
  task automatic wait_ready(input int first, output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    for (int c = first; c < first + 100; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (ready) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int bcnt;
    int early;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    signed_div = 1'b0;
    a = '0;
    b = '0;
    annul = 1'b0;

    vecs[0]  = '{32'd100,      32'd7,          1'b0, 32'd14,       32'd2,          33};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF,   33};
    vecs[2]  = '{32'h80000000, 32'hFFFFFFFF,   1'b1, 32'h80000000, 32'd0,          33};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF,   1'b0, 32'd0,        32'h80000000,   33};
    vecs[4]  = '{32'd5,        32'd0,          1'b1, 32'hFFFFFFFF, 32'd5,          1};
    vecs[5]  = '{32'd5,        32'd0,          1'b0, 32'hFFFFFFFF, 32'd5,          1};
    vecs[6]  = '{32'd7,        32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'd1,          33};
    vecs[7]  = '{32'hFFFFFFFF, 32'd1,          1'b0, 32'hFFFFFFFF, 32'd0,          33};
    vecs[8]  = '{32'hFFFFFF9C, 32'hFFFFFFF9,   1'b1, 32'd14,       32'hFFFFFFFE,   33};
    vecs[9]  = '{32'd3,        32'd10,         1'b0, 32'd0,        32'd3,          33};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF,   1'b0, 32'd1,        32'd0,          33};
    vecs[11] = '{32'd1000,     32'd33,         1'b0, 32'd30,       32'd10,         33};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_start(vecs[i].a, vecs[i].b, vecs[i].sgn);
      wait_ready(1, lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].lat);
      @(negedge clk);
      check($sformatf("v%0d_ready_pulse", i), {31'b0, ready}, 32'd0);
      check($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 32'd0);
    end

    // start and annul together in IDLE: rejected
    @(negedge clk);
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    annul = 1'b1;
    #1 check("annul_start_stall", {31'b0, stall}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    check("annul_start_busy", {31'b0, busy}, 32'd0);

    // annul mid-operation at cycle 10, restart at cycle 11
    do_start(32'd100, 32'd7, 1'b0);
    early = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (ready) early++;
    end
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    a = 32'd9;
    b = 32'd3;
    signed_div = 1'b0;
    start = 1'b1;
    @(negedge clk);
    if (ready) early++;
    check("annul_no_ready", early, 32'd0);
    check("annul_idle_busy", {31'b0, busy}, 32'd0);
    check("annul_keep_q", quotient, 32'd30);
    check("annul_keep_r", remainder, 32'd10);
    check("annul_restart_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready(12, lat, bcnt);
    check("restart_latency", lat, 32'd44);
    check("restart_quotient", quotient, 32'd3);
    check("restart_remainder", remainder, 32'd0);

    // async reset at cycle 15 of an operation
    do_start(32'd100, 32'd7, 1'b0);
    repeat (14) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ready", {31'b0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 50/5 with an ignored start pulse during BUSY
    do_start(32'd50, 32'd5, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk);
    a = 32'd1000;
    b = 32'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready(6, lat, bcnt);
    check("post_rst_latency", lat, 32'd33);
    check("post_rst_quotient", quotient, 32'd10);
    check("post_rst_remainder", remainder, 32'd0);
    @(negedge clk);
    check("post_rst_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
